if_stage: RTL and testbench

//   Instruction-fetch stage and IF/ID pipeline register of the low-spec MIPS pipeline.
//   - Holds the PC and fetches through a req/gnt/rvalid instruction-memory handshake.
//   - Buffers one instruction against ID stalls and supports EX-stage redirects.
//   - Presents instr[31:26] and instr[5:0] directly to the control unit (CU) in ID.

---
 rtl/if_stage.sv | 132 +++++++++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the MIPS pipeline.
// Fetches over a req/gnt/rvalid handshake and keeps one skid entry for ID stalls.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_id_valid_o,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc4_o,
   output logic [5:0]  op_o,
   output logic [5:0]  funct_o
);

   typedef enum logic [1:0] {StReq, StWait, StFull} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] fpc_q;
   logic        drop_q;
   logic [31:0] skid_instr_q;
   logic [31:0] skid_pc_q;
   logic        ifid_valid_q;
   logic [31:0] ifid_instr_q;
   logic [31:0] ifid_pc_q;
   logic [31:0] ifid_pc4_q;

   logic resp_live;
   logic load_fetch;
   logic load_skid;
   logic skid_wr;

   always_comb begin
      resp_live  = (state_q == StWait) && imem_rvalid_i && !drop_q;
      load_fetch = resp_live && (!ifid_valid_q || !stall_i);
      skid_wr    = resp_live && ifid_valid_q && stall_i;
      load_skid  = (state_q == StFull) && !stall_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StReq;
         pc_q         <= RESET_PC;
         fpc_q        <= RESET_PC;
         drop_q       <= 1'b0;
         skid_instr_q <= 32'h0;
         skid_pc_q    <= 32'h0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= 32'h0;
         ifid_pc_q    <= 32'h0;
         ifid_pc4_q   <= 32'h0;
      end else if (redirect_i) begin
         pc_q         <= {redirect_pc_i[31:2], 2'b00};
         ifid_valid_q <= 1'b0;
         // A response arriving this very cycle is the stale one; nothing is left to drop.
         if (state_q == StWait && !imem_rvalid_i) begin
            drop_q <= 1'b1;
         end else begin
            drop_q  <= 1'b0;
            state_q <= StReq;
         end
      end else begin
         if (!stall_i) begin
            ifid_valid_q <= 1'b0;
         end
         unique case (state_q)
            StReq: begin
               if (imem_gnt_i) begin
                  fpc_q   <= pc_q;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (imem_rvalid_i) begin
                  if (drop_q) begin
                     drop_q  <= 1'b0;
                     state_q <= StReq;
                  end else if (load_fetch) begin
                     ifid_valid_q <= 1'b1;
                     ifid_instr_q <= imem_rdata_i;
                     ifid_pc_q    <= fpc_q;
                     ifid_pc4_q   <= fpc_q + 32'd4;
                     state_q      <= StReq;
                  end else begin
                     skid_instr_q <= imem_rdata_i;
                     skid_pc_q    <= fpc_q;
                     state_q      <= StFull;
                  end
               end
            end
            StFull: begin
               if (load_skid) begin
                  ifid_valid_q <= 1'b1;
                  ifid_instr_q <= skid_instr_q;
                  ifid_pc_q    <= skid_pc_q;
                  ifid_pc4_q   <= skid_pc_q + 32'd4;
                  state_q      <= StReq;
               end
            end
            default: state_q <= StReq;
         endcase
         // Flush overrides any load or skid write made above in the same cycle.
         if (flush_i) begin
            ifid_valid_q <= 1'b0;
            if (state_q == StFull || skid_wr) begin
               state_q <= StReq;
            end
         end
      end
   end

   assign imem_req_o    = (state_q == StReq) && !redirect_i && !rst;
   assign imem_addr_o   = pc_q;
   assign if_id_valid_o = ifid_valid_q;
   assign if_id_instr_o = ifid_instr_q;
   assign if_id_pc_o    = ifid_pc_q;
   assign if_id_pc4_o   = ifid_pc4_q;
   assign op_o          = ifid_instr_q[31:26];
   assign funct_o       = ifid_instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scenario tasks with a scoreboard of expected IF/ID contents.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        stall, flush, redirect;
   logic [31:0] redirect_pc;
   logic        gnt, rvalid;
   logic [31:0] rdata;

   logic        req, valid;
   logic [31:0] addr, instr, pc, pc4;
   logic [5:0]  op, funct;

   logic        hi_req, hi_valid;
   logic [31:0] hi_addr, hi_instr, hi_pc, hi_pc4;
   logic [5:0]  hi_op, hi_funct;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_checks;
   int   n_fail;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .if_id_valid_o(valid),
      .if_id_instr_o(instr), .if_id_pc_o(pc), .if_id_pc4_o(pc4), .op_o(op), .funct_o(funct)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem_req_o(hi_req), .imem_addr_o(hi_addr),
      .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .if_id_valid_o(hi_valid), .if_id_instr_o(hi_instr), .if_id_pc_o(hi_pc),
      .if_id_pc4_o(hi_pc4), .op_o(hi_op), .funct_o(hi_funct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
      gnt = 0; rvalid = 0; rdata = 0;
      cyc(); cyc();
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr); end
      n_checks++; if (pc !== 32'h0 || pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h/%h exp 0/0", pc, pc4); end
      n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", addr); end
      n_checks++; if (hi_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_hi_addr got %h exp fffffffc", hi_addr); end
      rst = 1'b0;
      #1;
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL reset_req got %b exp 1", req); end
   endtask

   task automatic test_fetch();
      gnt = 1; cyc(); gnt = 0;
      n_checks++; if (addr !== 32'h4) begin n_fail++; $display("FAIL fetch_next_addr got %h exp 4", addr); end
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_req got %b exp 0", req); end
      rvalid = 1; rdata = 32'h0043_2020;
      sb_q.push_back({32'h0043_2020, 32'h0, 32'h4});
      cyc(); rvalid = 0;
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %b exp 1", valid); end
      e = sb_q.pop_front();
      n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL fetch_instr got %h exp %h", instr, e.instr); end
      n_checks++; if (pc !== e.pc || pc4 !== e.pc4) begin n_fail++; $display("FAIL fetch_pc got %h/%h exp %h/%h", pc, pc4, e.pc, e.pc4); end
      n_checks++; if (op !== 6'h00 || funct !== 6'h20) begin n_fail++; $display("FAIL fetch_op_funct got %h/%h exp 00/20", op, funct); end
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL fetch_req_again got %b exp 1", req); end
      cyc();
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_drop got %b exp 0", valid); end
   endtask

   task automatic test_stall_skid();
      gnt = 1; cyc(); gnt = 0;
      stall = 1; rvalid = 1; rdata = 32'h8C02_0000;
      sb_q.push_back({32'h8C02_0000, 32'h4, 32'h8});
      cyc(); rvalid = 0;
      e = sb_q.pop_front();
      n_checks++; if (valid !== 1'b1 || instr !== e.instr) begin n_fail++; $display("FAIL stall_first_load got %b/%h exp 1/%h", valid, instr, e.instr); end
      gnt = 1; cyc(); gnt = 0;
      rvalid = 1; rdata = 32'h2008_0005;
      sb_q.push_back({32'h2008_0005, 32'h8, 32'hC});
      cyc(); rvalid = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req[%0d] got %b exp 0", i, req); end
         n_checks++; if (valid !== 1'b1 || instr !== 32'h8C02_0000) begin n_fail++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/8c020000", i, valid, instr); end
         cyc();
      end
      stall = 0;
      cyc();
      e = sb_q.pop_front();
      n_checks++; if (valid !== 1'b1 || instr !== e.instr) begin n_fail++; $display("FAIL skid_move got %b/%h exp 1/%h", valid, instr, e.instr); end
      n_checks++; if (pc !== e.pc || pc4 !== e.pc4) begin n_fail++; $display("FAIL skid_pc got %h/%h exp %h/%h", pc, pc4, e.pc, e.pc4); end
      n_checks++; if (op !== 6'h08) begin n_fail++; $display("FAIL skid_op got %h exp 08", op); end
      n_checks++; if (req !== 1'b1 || addr !== 32'hC) begin n_fail++; $display("FAIL skid_next got %b/%h exp 1/c", req, addr); end
   endtask

   task automatic test_redirect();
      redirect = 1; redirect_pc = 32'h0000_0203;
      #1;
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL redirect_req_mask got %b exp 0", req); end
      cyc(); redirect = 0;
      #1;
      n_checks++; if (addr !== 32'h200 || req !== 1'b1) begin n_fail++; $display("FAIL redirect_req_state got %h/%b exp 200/1", addr, req); end
      gnt = 1; cyc(); gnt = 0;
      redirect = 1; redirect_pc = 32'h0000_0103;
      cyc(); redirect = 0;
      n_checks++; if (addr !== 32'h100 || req !== 1'b0) begin n_fail++; $display("FAIL redirect_wait got %h/%b exp 100/0", addr, req); end
      rvalid = 1; rdata = 32'hDEAD_BEEF;
      cyc(); rvalid = 0;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL redirect_drop_valid got %b exp 0", valid); end
      n_checks++; if (addr !== 32'h100 || req !== 1'b1) begin n_fail++; $display("FAIL redirect_resume got %h/%b exp 100/1", addr, req); end
      n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL redirect_sb got %0d exp 0", sb_q.size()); end
   endtask

   task automatic test_flush();
      gnt = 1; cyc(); gnt = 0;
      rvalid = 1; rdata = 32'h0128_5022; flush = 1;
      cyc(); rvalid = 0; flush = 0;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", valid); end
      n_checks++; if (addr !== 32'h104 || req !== 1'b1) begin n_fail++; $display("FAIL flush_pc got %h/%b exp 104/1", addr, req); end
      gnt = 1; cyc(); gnt = 0;
      rvalid = 1; rdata = 32'h0230_4025;
      sb_q.push_back({32'h0230_4025, 32'h104, 32'h108});
      cyc(); rvalid = 0;
      e = sb_q.pop_front();
      n_checks++; if (valid !== 1'b1 || instr !== e.instr) begin n_fail++; $display("FAIL flush_after got %b/%h exp 1/%h", valid, instr, e.instr); end
      n_checks++; if (pc !== e.pc || funct !== 6'h25 || addr !== 32'h108) begin n_fail++; $display("FAIL flush_seq got %h/%h/%h exp %h/25/108", pc, funct, addr, e.pc); end
   endtask

   task automatic test_wrap();
      rst = 1; cyc(); rst = 0;
      #1;
      n_checks++; if (hi_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset_addr got %h exp fffffffc", hi_addr); end
      gnt = 1; cyc(); gnt = 0;
      n_checks++; if (hi_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr got %h exp 0", hi_addr); end
      rvalid = 1; rdata = 32'h0800_0040;
      sb_q.push_back({32'h0800_0040, 32'hFFFF_FFFC, 32'h0});
      cyc(); rvalid = 0;
      e = sb_q.pop_front();
      n_checks++; if (hi_valid !== 1'b1 || hi_instr !== e.instr) begin n_fail++; $display("FAIL wrap_load got %b/%h exp 1/%h", hi_valid, hi_instr, e.instr); end
      n_checks++; if (hi_pc !== e.pc || hi_pc4 !== e.pc4) begin n_fail++; $display("FAIL wrap_pc got %h/%h exp %h/%h", hi_pc, hi_pc4, e.pc, e.pc4); end
   endtask

   task automatic test_reset_mid();
      stall = 1;
      gnt = 1; cyc(); gnt = 0;
      n_checks++; if (valid !== 1'b1 || addr !== 32'h8) begin n_fail++; $display("FAIL mid_pre got %b/%h exp 1/8", valid, addr); end
      rst = 1;
      #1;
      n_checks++; if (valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL mid_async got %b/%h exp 0/0", valid, instr); end
      n_checks++; if (addr !== 32'h0 || hi_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mid_addr got %h/%h exp 0/fffffffc", addr, hi_addr); end
      cyc(); rst = 0; stall = 0;
      rvalid = 1; rdata = 32'hCAFE_F00D;
      cyc(); rvalid = 0;
      n_checks++; if (valid !== 1'b0 || hi_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid got %b/%b exp 0/0", valid, hi_valid); end
      n_checks++; if (addr !== 32'h0 || req !== 1'b1) begin n_fail++; $display("FAIL mid_stale_addr got %h/%b exp 0/1", addr, req); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_fetch();
      test_stall_skid();
      test_redirect();
      test_flush();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
